pipe5_fetch_stage: RTL

Instruction-fetch stage of the 5-stage pipeline. It owns the PC register, drives the instruction-memory request, and fills the IF/ID latch consumed by decode. It applies the hazard unit's controls `pc_en`, `npc_sel`, `if_id_flush` and `stall`, and the privilege redirect `insert_priv_pc`/`priv_pc`. It also safely discards an in-flight fetch when the pipeline is redirected mid-access.

---
 rtl/pipe5_fetch_stage.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pipe5_fetch_stage.sv
// ============================================================================
//  Module   : pipe5_fetch_stage
//  Purpose  : Instruction-fetch stage. Owns the PC, issues imem requests and
//             fills the IF/ID latch. A redirect during a busy access is
//             absorbed by draining the in-flight fetch.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe5_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0200,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        pc_en,
    input  logic        stall,
    input  logic        if_id_flush,
    input  logic        npc_sel,
    input  logic [31:0] npc_target,
    input  logic        insert_priv_pc,
    input  logic [31:0] priv_pc,
    output logic        iren,
    output logic [31:0] imem_addr,
    input  logic        i_mem_busy,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        mal_insn,
    output logic [31:0] badaddr_i
);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_pend_pc;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_ifpc;
    logic [31:0] r_ifpc4;
    logic        r_mal;
    logic [31:0] r_badaddr;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_pend_nxt;
    logic        w_valid_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_ifpc_nxt;
    logic [31:0] w_ifpc4_nxt;
    logic        w_mal_nxt;
    logic [31:0] w_badaddr_nxt;

    logic        w_rd;
    logic [31:0] w_tgt;
    logic        w_aligned;
    logic        w_busy;
    logic        w_done;
    logic [31:0] w_pc_plus4;

    assign w_rd       = insert_priv_pc | npc_sel;
    assign w_tgt      = insert_priv_pc ? priv_pc : npc_target;
    assign w_aligned  = (r_pc[1:0] == 2'b00);
    assign w_pc_plus4 = r_pc + 32'd4;

    // While draining, the request must stay up at the old address until it completes.
    assign iren      = (r_state == ST_DRAIN) | w_aligned;
    assign imem_addr = {r_pc[31:2], 2'b00};

    // A misaligned PC issues no request, so busy is only meaningful with iren.
    assign w_busy = iren & i_mem_busy;
    assign w_done = iren & ~i_mem_busy;

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_pend_nxt    = r_pend_pc;
        w_valid_nxt   = r_valid;
        w_instr_nxt   = r_instr;
        w_ifpc_nxt    = r_ifpc;
        w_ifpc4_nxt   = r_ifpc4;
        w_mal_nxt     = r_mal;
        w_badaddr_nxt = r_badaddr;

        case (r_state)
            ST_FETCH: begin
                if (w_rd && w_busy) begin
                    w_pend_nxt    = w_tgt;
                    w_state_nxt   = ST_DRAIN;
                    w_valid_nxt   = 1'b0;
                    w_instr_nxt   = NOP_INSN;
                    w_mal_nxt     = 1'b0;
                    w_badaddr_nxt = 32'd0;
                end else if (w_rd) begin
                    w_pc_nxt      = w_tgt;
                    w_valid_nxt   = 1'b0;
                    w_instr_nxt   = NOP_INSN;
                    w_mal_nxt     = 1'b0;
                    w_badaddr_nxt = 32'd0;
                end else if (if_id_flush) begin
                    w_valid_nxt   = 1'b0;
                    w_instr_nxt   = NOP_INSN;
                    w_mal_nxt     = 1'b0;
                    w_badaddr_nxt = 32'd0;
                end else if (stall || !pc_en) begin
                    // Hold everything; any completed word is refetched later.
                    w_pc_nxt = r_pc;
                end else if (w_done) begin
                    w_valid_nxt   = 1'b1;
                    w_instr_nxt   = imem_rdata;
                    w_ifpc_nxt    = r_pc;
                    w_ifpc4_nxt   = w_pc_plus4;
                    w_mal_nxt     = 1'b0;
                    w_badaddr_nxt = 32'd0;
                    w_pc_nxt      = w_pc_plus4;
                end else if (!w_aligned) begin
                    // PC parks here until a redirect; the exception entry is re-posted.
                    w_valid_nxt   = 1'b1;
                    w_instr_nxt   = NOP_INSN;
                    w_ifpc_nxt    = r_pc;
                    w_ifpc4_nxt   = w_pc_plus4;
                    w_mal_nxt     = 1'b1;
                    w_badaddr_nxt = r_pc;
                end else begin
                    w_valid_nxt   = 1'b0;
                    w_instr_nxt   = NOP_INSN;
                    w_mal_nxt     = 1'b0;
                    w_badaddr_nxt = 32'd0;
                end
            end

            ST_DRAIN: begin
                w_valid_nxt   = 1'b0;
                w_instr_nxt   = NOP_INSN;
                w_mal_nxt     = 1'b0;
                w_badaddr_nxt = 32'd0;
                if (w_rd) begin
                    w_pend_nxt = w_tgt;
                end
                if (!i_mem_busy) begin
                    w_pc_nxt    = w_rd ? w_tgt : r_pend_pc;
                    w_state_nxt = ST_FETCH;
                end
            end

            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state   <= ST_FETCH;
            r_pc      <= RESET_PC;
            r_pend_pc <= 32'd0;
            r_valid   <= 1'b0;
            r_instr   <= NOP_INSN;
            r_ifpc    <= 32'd0;
            r_ifpc4   <= 32'd0;
            r_mal     <= 1'b0;
            r_badaddr <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_pend_pc <= w_pend_nxt;
            r_valid   <= w_valid_nxt;
            r_instr   <= w_instr_nxt;
            r_ifpc    <= w_ifpc_nxt;
            r_ifpc4   <= w_ifpc4_nxt;
            r_mal     <= w_mal_nxt;
            r_badaddr <= w_badaddr_nxt;
        end
    end

    assign if_id_valid = r_valid;
    assign if_id_instr = r_instr;
    assign if_id_pc    = r_ifpc;
    assign if_id_pc4   = r_ifpc4;
    assign mal_insn    = r_mal;
    assign badaddr_i   = r_badaddr;

endmodule

`default_nettype wire
